// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the memory and mem_port_arbiter.
// master = requesters + memory model side, slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32
);
  // Handshake: a requester raises reqN with stable addr/we/wdata and holds it
  // until gntN (a one-cycle pulse) is seen; the transfer then completes with
  // a one-cycle doneN carrying rdata. Memory side: mem_req is held high while
  // an access is open and the access completes on the first cycle with mem_ready.
  logic              req0;
  logic [DATA_W-1:0] addr0;
  logic              req1;
  logic [DATA_W-1:0] addr1;
  logic              we1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              mux_sel;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;

  modport master (
    output req0, addr0, req1, addr1, we1, wdata1, mem_ready, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, mux_sel, mem_req, mem_addr,
           mem_we, mem_wdata, err
  );

  modport slave (
    input  req0, addr0, req1, addr1, we1, wdata1, mem_ready, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, mux_sel, mem_req, mem_addr,
           mem_we, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter for one single-port memory, with port-0 starvation guard.
// Optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           state_dbg  // 0 = IDLE, 1 = BUSY0, 2 = BUSY1
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 2 || TIMEOUT > 255 || DATA_W < 1)
  begin : g_bad_cfg
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       starved;
  logic       win0;
  logic       win1;

  // Data port normally wins; fetch is forced through once it has lost STARVE_MAX times in a row.
  assign starved   = bus.req0 && (starve_cnt == 4'(STARVE_MAX));
  assign win1      = (state == IDLE) && bus.req1 && !starved;
  assign win0      = (state == IDLE) && bus.req0 && !win1;
  assign bus.gnt0  = win0;
  assign bus.gnt1  = win1;
  assign state_dbg = state;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       time_up;
  // tcnt would step to TIMEOUT-1 at this edge: the access has had its last chance.
  assign time_up = (tcnt == 8'(TIMEOUT - 2));
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= 4'd0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mux_sel   <= 1'b0;
      bus.mem_addr  <= {DATA_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.rdata     <= {DATA_W{1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
      tcnt          <= 8'd0;
      bus.err       <= 1'b0;
`endif
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win1) begin
            state         <= BUSY1;
            bus.mux_sel   <= 1'b1;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= bus.addr1;
            bus.mem_we    <= bus.we1;
            bus.mem_wdata <= bus.wdata1;
            if (bus.req0 && starve_cnt != 4'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (win0) begin
            state         <= BUSY0;
            bus.mux_sel   <= 1'b0;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= bus.addr0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= {DATA_W{1'b0}};
            starve_cnt    <= 4'd0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          tcnt <= 8'd0;
`endif
        end
        BUSY0, BUSY1: begin
          // Read data is captured for writes as well; the requester ignores it.
          if (bus.mem_ready) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            bus.rdata   <= bus.mem_rdata;
            bus.done0   <= (state == BUSY0);
            bus.done1   <= (state == BUSY1);
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (time_up) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            bus.rdata   <= {DATA_W{1'b0}};
            bus.done0   <= (state == BUSY0);
            bus.done1   <= (state == BUSY1);
            bus.err     <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration and memory-access rules.
module tb_mem_port_arbiter;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // One open access at most; tracks who owns memory, what was latched, how long the
  // fetch port has been waiting, and the read data each done should return.
  bit          seen_rst = 1'b0;
  bit          m_busy, m_port, m_we, m_sel, m_d0, m_d1, m_err;
  int          m_loss, m_age;
  logic [DW-1:0] m_addr, m_wdata, m_rdata, exp_rd;
  bit          e_g0, e_g1;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    e_g1 = !m_busy && bus.req1 && !(bus.req0 && m_loss >= SMAX);
    e_g0 = !m_busy && bus.req0 && !e_g1;
    if (seen_rst) begin
      check("gnt0", bus.gnt0, e_g0);
      check("gnt1", bus.gnt1, e_g1);
      check("done0", bus.done0, m_d0);
      check("done1", bus.done1, m_d1);
      check("mem_req", bus.mem_req, m_busy);
      check("mux_sel", bus.mux_sel, m_sel);
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_we", bus.mem_we, m_we);
      check("mem_wdata", bus.mem_wdata, m_wdata);
      check("err", bus.err, m_err);
      check("state_dbg", state_dbg, m_busy ? (m_port ? 2 : 1) : 0);
      if ((m_d0 || m_d1) && exp_q.size() > 0) begin
        exp_rd = exp_q.pop_front();
        check("rdata_done", bus.rdata, exp_rd);
      end else begin
        check("rdata_hold", bus.rdata, m_rdata);
      end
    end
    // effect of the coming clock edge
    if (rst) begin
      m_busy = 0; m_port = 0; m_we = 0; m_sel = 0; m_d0 = 0; m_d1 = 0; m_err = 0;
      m_loss = 0; m_age = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      exp_q.delete();
      seen_rst = 1'b1;
    end else begin
      m_d0 = 0; m_d1 = 0; m_err = 0;
      if (m_busy) begin
        if (bus.mem_ready) begin
          m_busy = 0;
          if (m_port) m_d1 = 1; else m_d0 = 1;
          m_rdata = bus.mem_rdata;
          exp_q.push_back(bus.mem_rdata);
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else begin
          m_age++;
          if (m_age == TMO - 1) begin
            m_busy = 0;
            if (m_port) m_d1 = 1; else m_d0 = 1;
            m_err = 1;
            m_rdata = '0;
            exp_q.push_back('0);
          end
        end
`endif
      end else if (e_g1) begin
        m_busy = 1; m_port = 1; m_sel = 1; m_age = 0;
        m_addr = bus.addr1; m_we = bus.we1; m_wdata = bus.wdata1;
        if (bus.req0) m_loss = (m_loss < SMAX) ? m_loss + 1 : SMAX;
      end else if (e_g0) begin
        m_busy = 1; m_port = 0; m_sel = 0; m_age = 0;
        m_addr = bus.addr0; m_we = 0; m_wdata = '0;
        m_loss = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic          s_g0, s_g1, s_d0, s_d1, s_mreq, s_mux, s_we, s_err;
  logic [DW-1:0] s_addr, s_wdata, s_rdata;

  // Sample the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_g0 = bus.gnt0; s_g1 = bus.gnt1; s_d0 = bus.done0; s_d1 = bus.done1;
    s_mreq = bus.mem_req; s_mux = bus.mux_sel; s_we = bus.mem_we; s_err = bus.err;
    s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_rdata = bus.rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input bit port);
    int n;
    n = 0;
    tick();
    while (!(port ? s_g1 : s_g0)) begin
      n++;
      if (n > 32) begin
        check("gnt_wait", port ? s_g1 : s_g0, 1);
        return;
      end
      tick();
    end
  endtask

  task automatic run_txn(input bit port, input logic [DW-1:0] addr, input bit we,
                         input logic [DW-1:0] wd, input int wait_n, input logic [DW-1:0] rd);
    if (port) begin
      bus.req1 = 1'b1; bus.addr1 = addr; bus.we1 = we; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.addr0 = addr;
    end
    bus.mem_ready = 1'b0;
    wait_gnt(port);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int k = 1; k <= wait_n; k++) begin
      bus.mem_ready = (k == wait_n);
      bus.mem_rdata = (k == wait_n) ? rd : $urandom;
      tick();
      check("txn_mem_req", s_mreq, 1);
      check("txn_mux_sel", s_mux, port);
      check("txn_mem_addr", s_addr, addr);
      check("txn_mem_we", s_we, port ? we : 1'b0);
      check("txn_mem_wdata", s_wdata, port ? wd : '0);
    end
    bus.mem_ready = 1'b0;
    tick();
    check("txn_done", port ? s_d1 : s_d0, 1);
    check("txn_rdata", s_rdata, rd);
    check("txn_idle", s_mreq, 0);
  endtask

  // ---------------- stimulus ----------------
  int gport[$];
  int gcyc[$];
  int n;

  initial begin
    bus.req0 = 0; bus.addr0 = '0; bus.req1 = 0; bus.addr1 = '0;
    bus.we1 = 0; bus.wdata1 = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
    do_reset();
    tick();
    check("rst_mem_req", s_mreq, 0);
    check("rst_mux_sel", s_mux, 0);
    check("rst_mem_addr", s_addr, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_err", s_err, 0);

    run_txn(1'b0, 32'h0000_1000, 1'b0, '0, 3, 32'hDEAD_BEEF);
    run_txn(1'b1, 32'h0000_2000, 1'b1, 32'h1234_5678, 1, 32'h0BAD_F00D);

    // both ports hold requests, memory always ready
    do_reset();
    bus.req0 = 1; bus.addr0 = 32'h100; bus.req1 = 1; bus.addr1 = 32'h200; bus.we1 = 0;
    bus.mem_ready = 1;
    for (int c = 0; c < 20; c++) begin
      bus.mem_rdata = $urandom;
      tick();
      if (s_g0) begin gport.push_back(0); gcyc.push_back(c); end
      if (s_g1) begin gport.push_back(1); gcyc.push_back(c); end
    end
    bus.req0 = 0; bus.req1 = 0;
    check("starve_ngrants", gport.size(), 10);
    for (int k = 0; k < 10 && k < gport.size(); k++) begin
      check("starve_port", gport[k], ((k + 1) % (SMAX + 1) == 0) ? 0 : 1);
      if (k > 0) check("starve_gap", gcyc[k] - gcyc[k-1], 2);
    end
    bus.mem_ready = 0;
    tick();

    // fetch request arriving while data port owns memory
    bus.req1 = 1; bus.addr1 = 32'h3000; bus.we1 = 0;
    wait_gnt(1'b1);
    bus.req1 = 0; bus.req0 = 1; bus.addr0 = 32'h4000;
    for (int k = 1; k <= 3; k++) begin
      bus.mem_ready = (k == 3); bus.mem_rdata = $urandom;
      tick();
      check("b2b_no_gnt0", s_g0, 0);
    end
    bus.mem_ready = 0;
    tick();
    check("b2b_done1", s_d1, 1);
    check("b2b_gnt0", s_g0, 1);
    bus.req0 = 0; bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    tick();

    // reset in the second busy cycle of a port-1 write
    bus.req1 = 1; bus.addr1 = 32'h5000; bus.we1 = 1; bus.wdata1 = 32'hA5A5_A5A5;
    wait_gnt(1'b1);
    bus.req1 = 0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_mem_req", s_mreq, 0);
    check("rstmid_mux_sel", s_mux, 0);
    check("rstmid_mem_we", s_we, 0);
    check("rstmid_mem_wdata", s_wdata, 0);
    check("rstmid_mem_addr", s_addr, 0);
    check("rstmid_done1", s_d1, 0);
    bus.mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rstmid_no_done1", s_d1, 0);
    end
    bus.mem_ready = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    bus.req0 = 1; bus.addr0 = 32'h6000;
    wait_gnt(1'b0);
    bus.req0 = 0;
    n = 0;
    tick();
    while (s_mreq && n < 40) begin
      n++;
      tick();
    end
    check("to_busy_cycles", n, TMO - 1);
    check("to_done0", s_d0, 1);
    check("to_err", s_err, 1);
    check("to_rdata", s_rdata, 0);
    bus.req0 = 1; bus.addr0 = 32'h6004;
    wait_gnt(1'b0);
    bus.req0 = 0;
    for (int k = 1; k <= TMO - 1; k++) begin
      bus.mem_ready = (k == TMO - 1);
      bus.mem_rdata = (k == TMO - 1) ? 32'hCAFE_0001 : $urandom;
      tick();
    end
    bus.mem_ready = 0;
    tick();
    check("to_late_done0", s_d0, 1);
    check("to_late_err", s_err, 0);
    check("to_late_rdata", s_rdata, 32'hCAFE_0001);
`endif

    // random traffic; the model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (!bus.req0 || s_g0) begin
        bus.req0 = 1'($urandom_range(0, 1));
        bus.addr0 = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.req0 = 1'b0;
      end
      if (!bus.req1 || s_g1) begin
        bus.req1 = 1'($urandom_range(0, 1));
        bus.addr1 = $urandom;
        bus.we1 = 1'($urandom_range(0, 1));
        bus.wdata1 = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.req1 = 1'b0;
      end
      bus.mem_ready = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
      tick();
    end
    rst = 1'b0; bus.req0 = 0; bus.req1 = 0; bus.mem_ready = 1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
